// File: rtl/id_latch.sv
`default_nettype none
// ============================================================================
//  Module   : id_latch
//  Purpose  : IF/ID pipeline register with load-use hazard detection.
//  Revision : 1.0  initial release
// ============================================================================
module id_latch #(
    parameter int unsigned FLUSH_ON_JUMP = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              do_jump,
    input  logic [31:0]       if_ins,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_next_pc,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    output logic [31:0]       id_ins,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_next_pc,
    output logic              id_valid,
    output logic              id_is_sync,
    output logic              fetch_bubble,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  hazard_cnt
);

    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_VALID   = 2'd1;
    localparam logic [1:0] c_ST_LOADUSE = 2'd2;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_FN_SYNC    = 6'h0F;

    logic [1:0]       state_q,      state_d;
    logic [31:0]      id_ins_q,     id_ins_d;
    logic [31:0]      id_pc_q,      id_pc_d;
    logic [31:0]      id_next_pc_q, id_next_pc_d;
    logic             id_valid_q,   id_valid_d;
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_hazard;
    logic       w_flush;
    logic       w_cnt_sat;

    assign w_op    = id_ins_q[31:26];
    assign w_rs    = id_ins_q[25:21];
    assign w_rt    = id_ins_q[20:16];
    assign w_funct = id_ins_q[5:0];

    // J/JAL/LUI and the shift-by-immediate R-types never read rs.
    assign w_uses_rs = !((w_op == 6'h02) || (w_op == 6'h03) || (w_op == 6'h0F) ||
                         ((w_op == c_OP_SPECIAL) &&
                          ((w_funct == 6'h00) || (w_funct == 6'h02) || (w_funct == 6'h03))));

    assign w_uses_rt = (w_op == c_OP_SPECIAL) || (w_op == 6'h04) || (w_op == 6'h05) ||
                       (w_op == 6'h28) || (w_op == 6'h29) || (w_op == 6'h2B);

    // Only VALID can hazard, which limits every instruction to a single bubble.
    assign w_hazard = (state_q == c_ST_VALID) && ex_mem_read && (ex_rt != 5'd0) &&
                      ((w_uses_rs && (w_rs == ex_rt)) || (w_uses_rt && (w_rt == ex_rt)));

    assign w_flush   = do_jump && (FLUSH_ON_JUMP != 0);
    assign w_cnt_sat = (hazard_cnt_q == {CNT_W{1'b1}});

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= c_ST_EMPTY;
            id_ins_q     <= 32'd0;
            id_pc_q      <= 32'd0;
            id_next_pc_q <= 32'd0;
            id_valid_q   <= 1'b0;
            hazard_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            id_ins_q     <= id_ins_d;
            id_pc_q      <= id_pc_d;
            id_next_pc_q <= id_next_pc_d;
            id_valid_q   <= id_valid_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        id_ins_d     = id_ins_q;
        id_pc_d      = id_pc_q;
        id_next_pc_d = id_next_pc_q;
        id_valid_d   = id_valid_q;
        hazard_cnt_d = hazard_cnt_q;

        if (stall) begin
            state_d = state_q;
        end else if (w_flush) begin
            // PC fields still follow fetch so the killed slot stays traceable.
            state_d      = c_ST_EMPTY;
            id_ins_d     = 32'd0;
            id_valid_d   = 1'b0;
            id_pc_d      = if_pc;
            id_next_pc_d = if_next_pc;
        end else if (w_hazard) begin
            state_d = c_ST_LOADUSE;
            if (!w_cnt_sat) begin
                hazard_cnt_d = hazard_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            state_d      = c_ST_VALID;
            id_ins_d     = if_ins;
            id_pc_d      = if_pc;
            id_next_pc_d = if_next_pc;
            id_valid_d   = 1'b1;
        end
    end

    always_comb begin
        id_ins       = id_ins_q;
        id_pc        = id_pc_q;
        id_next_pc   = id_next_pc_q;
        id_valid     = id_valid_q;
        hazard_cnt   = hazard_cnt_q;
        id_is_sync   = (w_op == c_OP_SPECIAL) && (w_funct == c_FN_SYNC);
        fetch_bubble = w_hazard && !stall && !w_flush;
        ex_bubble    = w_hazard && !stall && !w_flush;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_latch
//  Purpose  : Directed plus randomized checks of id_latch against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_latch;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        stall   = 1'b0;
    logic        do_jump = 1'b0;
    logic [31:0] if_ins  = 32'd0;
    logic [31:0] if_pc   = 32'd0;
    logic [31:0] if_next_pc = 32'd0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt   = 5'd0;

    logic [31:0] id_ins, id_pc, id_next_pc;
    logic        id_valid, id_is_sync, fetch_bubble, ex_bubble;
    logic [15:0] hazard_cnt;

    logic [31:0] s_ins, s_pc, s_next_pc;
    logic        s_valid, s_sync, s_fb, s_eb;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ins, m_pc, m_npc;
    logic        m_valid;
    logic        m_bubbled;
    int          m_hazards;

    always #5 sys_clk = ~sys_clk;

    id_latch #(.FLUSH_ON_JUMP(1), .CNT_W(16)) u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .stall(stall), .do_jump(do_jump),
        .if_ins(if_ins), .if_pc(if_pc), .if_next_pc(if_next_pc),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_ins(id_ins), .id_pc(id_pc), .id_next_pc(id_next_pc),
        .id_valid(id_valid), .id_is_sync(id_is_sync),
        .fetch_bubble(fetch_bubble), .ex_bubble(ex_bubble), .hazard_cnt(hazard_cnt)
    );

    id_latch #(.FLUSH_ON_JUMP(1), .CNT_W(2)) u_sat (
        .sys_clk(sys_clk), .rst_n(rst_n), .stall(stall), .do_jump(do_jump),
        .if_ins(if_ins), .if_pc(if_pc), .if_next_pc(if_next_pc),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_ins(s_ins), .id_pc(s_pc), .id_next_pc(s_next_pc),
        .id_valid(s_valid), .id_is_sync(s_sync),
        .fetch_bubble(s_fb), .ex_bubble(s_eb), .hazard_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (op == 2 || op == 3 || op == 15) return 1'b0;
        if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit reads_rt(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        return (op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43);
    endfunction

    function automatic bit model_hazard();
        bit dep;
        if (!m_valid || m_bubbled || !ex_mem_read || ex_rt == 5'd0) return 1'b0;
        dep = (reads_rs(m_ins) && m_ins[25:21] == ex_rt) ||
              (reads_rt(m_ins) && m_ins[20:16] == ex_rt);
        return dep;
    endfunction

    function automatic logic [31:0] sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic model_reset();
        m_ins = 0; m_pc = 0; m_npc = 0; m_valid = 0; m_bubbled = 0; m_hazards = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ins"},   id_ins,     m_ins);
        chk({tag, ".pc"},    id_pc,      m_pc);
        chk({tag, ".npc"},   id_next_pc, m_npc);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, m_valid});
        chk({tag, ".cnt"},   {16'd0, hazard_cnt}, sat(m_hazards, 65535));
        chk({tag, ".scnt"},  {30'd0, s_cnt}, sat(m_hazards, 3));
        chk({tag, ".sins"},  s_ins, m_ins);
    endtask

    // Called at a negedge with inputs already applied.
    task automatic cycle(input string tag);
        bit hz, bub;
        #1;
        hz  = model_hazard();
        bub = hz && !stall && !do_jump;
        chk({tag, ".fb"},   {31'd0, fetch_bubble}, {31'd0, bub});
        chk({tag, ".eb"},   {31'd0, ex_bubble},    {31'd0, bub});
        chk({tag, ".sfb"},  {31'd0, s_fb},         {31'd0, bub});
        chk({tag, ".sync"}, {31'd0, id_is_sync},
            {31'd0, (m_ins[31:26] == 6'h00 && m_ins[5:0] == 6'h0F)});
        @(posedge sys_clk);
        #1;
        if (!stall) begin
            if (do_jump) begin
                m_ins = 0; m_valid = 0; m_bubbled = 0; m_pc = if_pc; m_npc = if_next_pc;
            end else if (hz) begin
                m_bubbled = 1; m_hazards++;
            end else begin
                m_ins = if_ins; m_pc = if_pc; m_npc = if_next_pc; m_valid = 1; m_bubbled = 0;
            end
        end
        check_all(tag);
        @(negedge sys_clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                         input logic jmp, input logic mr, input logic [4:0] rt, input string tag);
        if_ins = ins; if_pc = pc; if_next_pc = pc + 32'd4;
        stall = st; do_jump = jmp; ex_mem_read = mr; ex_rt = rt;
        cycle(tag);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops [9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h28, 6'h2B, 6'h08};
        logic [5:0] fns [5] = '{6'h00, 6'h02, 6'h21, 6'h0F, 6'h08};
        logic [5:0] op = ops[$urandom_range(8)];
        logic [5:0] fn = fns[$urandom_range(4)];
        logic [4:0] rs = 5'($urandom_range(3));
        logic [4:0] rt = 5'($urandom_range(3));
        if ($urandom_range(15) == 0) return 32'd0;
        return {op, rs, rt, 5'd7, 5'd0, fn};
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge sys_clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Flow
        drive(32'h8C0A0000, 32'h100, 0, 0, 0, 5'd0,  "flow0");
        chk("flow0.ins_const", id_ins, 32'h8C0A0000);
        drive(32'h01495020, 32'h104, 0, 0, 0, 5'd0,  "flow1");
        chk("flow1.pc_const", id_pc, 32'h104);

        // Load-use on rs=$t2
        drive(32'h00000000, 32'h108, 0, 0, 1, 5'd10, "lu0");
        chk("lu0.cnt_const", {16'd0, hazard_cnt}, 32'd1);
        drive(32'h00000000, 32'h108, 0, 0, 1, 5'd10, "lu1");

        // Stall overlapping a hazard on rt=$t1
        drive(32'h01495020, 32'h10C, 0, 0, 0, 5'd0,  "st_ld");
        for (int i = 0; i < 3; i++) drive(32'h11111111, 32'h110, 1, 0, 1, 5'd9, "st_hold");
        drive(32'h11111111, 32'h110, 0, 0, 1, 5'd9,  "st_bub");
        drive(32'h11111111, 32'h110, 1, 0, 1, 5'd9,  "st_lu_hold");
        drive(32'h22222222, 32'h114, 0, 0, 1, 5'd9,  "st_after");

        // Flush beats hazard
        drive(32'h01495020, 32'h118, 0, 0, 0, 5'd0,  "fl_ld");
        drive(32'h33333333, 32'h11C, 0, 1, 1, 5'd10, "fl_jump");
        chk("fl.valid_const", {31'd0, id_valid}, 32'd0);

        // Corners
        drive(32'h01495020, 32'h120, 0, 0, 0, 5'd0,  "c_ld");
        drive(32'h0000000F, 32'h124, 0, 0, 1, 5'd0,  "c_rt0");
        drive(32'h00000000, 32'h128, 0, 0, 1, 5'd10, "c_sync");
        chk("c_sync.const", {31'd0, id_is_sync}, 32'd0);

        // Async reset mid-cycle with a live slot
        drive(32'h01495020, 32'h12C, 0, 0, 0, 5'd0,  "r_ld");
        if_ins = 32'h01495020; ex_mem_read = 1; ex_rt = 5'd10;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.fb",   {31'd0, fetch_bubble}, 32'd0);
        chk("arst.eb",   {31'd0, ex_bubble},    32'd0);
        chk("arst.sync", {31'd0, id_is_sync},   32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(rand_ins(), 32'h1000 + 32'(i * 4), ($urandom_range(4) == 0),
                  ($urandom_range(9) == 0), ($urandom_range(1) == 1),
                  5'($urandom_range(3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
